// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG seed collector: FSM states,
// block size and operation codes.
package trng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE_LAST,
        CHECK,
        LAUNCH,
        WAIT_DONE,
        DONE,
        FAIL
    } state_t;

    localparam int         WORDS     = 16;
    localparam logic [1:0] OP_RESEED = 2'b11;

endpackage

// File: rtl/trng_health_test.sv
// Repetition-count and all-zero health test over a stream of 32-bit words.
// The fail flag is valid once the last word of a block has been presented.
module trng_health_test #(
    parameter int REP_LIMIT = 3
) (
    input  logic        clk,
    input  logic        Resetn,
    input  logic        clr,
    input  logic        valid,
    input  logic [31:0] word,
    output logic        fail
);

    logic [31:0] prev;
    logic [4:0]  run;
    logic [4:0]  run_n;
    logic        seen;
    logic        rep;
    logic        nz;

    assign run_n = (seen && word == prev) ? run + 5'd1 : 5'd1;
    assign fail  = rep | ~nz;

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            prev <= '0;
            run  <= '0;
            seen <= 1'b0;
            rep  <= 1'b0;
            nz   <= 1'b0;
        end else if (clr) begin
            prev <= '0;
            run  <= '0;
            seen <= 1'b0;
            rep  <= 1'b0;
            nz   <= 1'b0;
        end else if (valid) begin
            prev <= word;
            seen <= 1'b1;
            run  <= run_n;
            if (run_n >= 5'(REP_LIMIT))
                rep <= 1'b1;
            if (word != '0)
                nz <= 1'b1;
        end
    end

endmodule

// File: rtl/trng_sram_collector.sv
// Gathers a 16-word seed block from SRAM, health-checks it and hands
// it to the TRNG core, with a watchdog on the core's completion.
module trng_sram_collector
    import trng_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int REP_LIMIT = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         Resetn,
    input  logic         Collect_Go,
    input  logic [1:0]   Op_Type_In,
    input  logic [1:0]   Bank_Sel,
    output logic         sram_rd_en,
    output logic [5:0]   sram_addr,
    input  logic [31:0]  sram_rdata,
    output logic         TRNG_Go,
    output logic [1:0]   Op_Type,
    output logic [511:0] data_in,
    input  logic         TRNG_Done,
    output logic         Busy,
    output logic         Collect_Done,
    output logic         Health_Fail,
    output logic         Timeout
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic [3:0]    rd_k;
    logic [3:0]    cap_k;
    logic          rd_q;
    logic          start;
    logic          hfail;
    logic [TW-1:0] tmr;

    assign start = (state == IDLE) && Collect_Go;

    trng_health_test #(
        .REP_LIMIT(REP_LIMIT)
    ) u_health (
        .clk   (clk),
        .Resetn(Resetn),
        .clr   (start),
        .valid (rd_q),
        .word  (sram_rdata),
        .fail  (hfail)
    );

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            rd_k         <= '0;
            cap_k        <= '0;
            rd_q         <= 1'b0;
            tmr          <= '0;
            sram_rd_en   <= 1'b0;
            sram_addr    <= '0;
            TRNG_Go      <= 1'b0;
            Op_Type      <= '0;
            data_in      <= '0;
            Busy         <= 1'b0;
            Collect_Done <= 1'b0;
            Health_Fail  <= 1'b0;
            Timeout      <= 1'b0;
        end else begin
            TRNG_Go      <= 1'b0;
            Collect_Done <= 1'b0;
            // SRAM data lags the strobe by one cycle
            rd_q         <= sram_rd_en;
            if (rd_q) begin
                data_in[{cap_k, 5'd0} +: 32] <= sram_rdata;
                cap_k <= cap_k + 4'd1;
            end
            unique case (state)
                IDLE: begin
                    if (Collect_Go) begin
                        Op_Type     <= Op_Type_In;
                        Health_Fail <= 1'b0;
                        Timeout     <= 1'b0;
                        data_in     <= '0;
                        cap_k       <= '0;
                        rd_k        <= '0;
                        Busy        <= 1'b1;
                        if (Op_Type_In == OP_RESEED) begin
                            state   <= LAUNCH;
                            TRNG_Go <= 1'b1;
                        end else begin
                            state      <= READ;
                            sram_rd_en <= 1'b1;
                            sram_addr  <= 6'(BASE_ADDR) + {Bank_Sel, 4'b0};
                        end
                    end
                end
                READ: begin
                    rd_k <= rd_k + 4'd1;
                    if (rd_k == 4'(WORDS - 1)) begin
                        sram_rd_en <= 1'b0;
                        state      <= CAPTURE_LAST;
                    end else begin
                        sram_addr <= sram_addr + 6'd1;
                    end
                end
                CAPTURE_LAST: state <= CHECK;
                CHECK: begin
                    if (hfail) begin
                        state        <= FAIL;
                        Health_Fail  <= 1'b1;
                        Collect_Done <= 1'b1;
                    end else begin
                        state   <= LAUNCH;
                        TRNG_Go <= 1'b1;
                    end
                end
                LAUNCH: begin
                    tmr   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // expiry lands DONE exactly TIMEOUT cycles after LAUNCH
                    if (TRNG_Done || tmr == TW'(TIMEOUT - 2)) begin
                        Timeout      <= !TRNG_Done;
                        Collect_Done <= 1'b1;
                        state        <= DONE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                DONE, FAIL: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_sram_collector.sv
// Self-checking bench: timeline model of each collection run, compared
// every cycle against two collector instances (BASE_ADDR 0 and 60).
module tb_trng_sram_collector;

    localparam int B1  = 60;
    localparam int REP = 3;

    logic         clk = 1'b0;
    logic         Resetn = 1'b1;
    logic         Collect_Go = 1'b0;
    logic         TRNG_Done = 1'b0;
    logic [1:0]   Op_Type_In = '0;
    logic [1:0]   Bank_Sel = '0;
    logic         rd0, rd1, go0, go1, busy0, busy1;
    logic         cd0, cd1, hf0, hf1, to0, to1;
    logic [5:0]   a0, a1;
    logic [31:0]  rdata0 = '0;
    logic [31:0]  rdata1 = '0;
    logic [1:0]   op0, op1;
    logic [511:0] d0, d1;
    logic [31:0]  mem0 [64];
    logic [31:0]  mem1 [64];

    int npass = 0;
    int nchk  = 0;
    int cyc   = 0;

    bit           act = 1'b0;
    int           s, L, D, dly;
    logic [1:0]   mop, mbank;
    logic         mfail;
    logic [31:0]  pat [16];
    logic [511:0] hold_data = '0;
    logic [1:0]   hold_op = '0;
    logic         hold_hf = 1'b0;
    logic         hold_to = 1'b0;

    int           t;
    logic         e_rd, e_go, e_busy, e_cd, e_hf, e_to;
    logic [511:0] e_d;
    logic [1:0]   e_op;

    int           go_n, rd_n, cd_n, go_c, cd_c;
    logic [5:0]   fa0, fa1, la1;
    bit           seen_rd;

    trng_sram_collector u_dut0 (
        .clk(clk), .Resetn(Resetn), .Collect_Go(Collect_Go),
        .Op_Type_In(Op_Type_In), .Bank_Sel(Bank_Sel),
        .sram_rd_en(rd0), .sram_addr(a0), .sram_rdata(rdata0),
        .TRNG_Go(go0), .Op_Type(op0), .data_in(d0),
        .TRNG_Done(TRNG_Done), .Busy(busy0), .Collect_Done(cd0),
        .Health_Fail(hf0), .Timeout(to0)
    );

    trng_sram_collector #(.BASE_ADDR(B1)) u_dut1 (
        .clk(clk), .Resetn(Resetn), .Collect_Go(Collect_Go),
        .Op_Type_In(Op_Type_In), .Bank_Sel(Bank_Sel),
        .sram_rd_en(rd1), .sram_addr(a1), .sram_rdata(rdata1),
        .TRNG_Go(go1), .Op_Type(op1), .data_in(d1),
        .TRNG_Done(TRNG_Done), .Busy(busy1), .Collect_Done(cd1),
        .Health_Fail(hf1), .Timeout(to1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous SRAMs, one-cycle read latency
    always @(posedge clk) begin
        if (rd0) rdata0 <= mem0[a0];
        if (rd1) rdata1 <= mem1[a1];
    end

    task automatic chk(input string nm, input logic [511:0] a,
                       input logic [511:0] e);
        nchk++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, a, e);
    endtask

    function automatic logic [31:0] patv(input int pid, input int k);
        case (pid)
            0: return 32'(17 + k);
            1: return (k >= 4 && k <= 6) ? 32'hA5A5A5A5 : 32'(100 + 3 * k);
            2: return 32'h0;
            3: return 32'hC0DE0000 + 32'(k);
            default: return (k == 2 || k == 3) ? 32'h55 : 32'(200 + k);
        endcase
    endfunction

    function automatic logic model_fail();
        logic allz;
        allz = 1'b1;
        for (int k = 0; k < 16; k++)
            if (pat[k] != 0) allz = 1'b0;
        if (allz) return 1'b1;
        for (int w = 0; w <= 16 - REP; w++) begin
            logic same;
            same = 1'b1;
            for (int j = 1; j < REP; j++)
                if (pat[w + j] != pat[w]) same = 1'b0;
            if (same) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic cmp(input string id, input logic rd, go, busy, cd, hf, to,
                       input logic [5:0] a, input logic [1:0] op,
                       input logic [511:0] d, input int base);
        chk({id, ".sram_rd_en"}, 512'(rd), 512'(e_rd));
        chk({id, ".TRNG_Go"}, 512'(go), 512'(e_go));
        chk({id, ".Busy"}, 512'(busy), 512'(e_busy));
        chk({id, ".Collect_Done"}, 512'(cd), 512'(e_cd));
        chk({id, ".Health_Fail"}, 512'(hf), 512'(e_hf));
        chk({id, ".Timeout"}, 512'(to), 512'(e_to));
        chk({id, ".Op_Type"}, 512'(op), 512'(e_op));
        chk({id, ".data_in"}, d, e_d);
        if (e_rd)
            chk({id, ".sram_addr"}, 512'(a),
                512'((base + 16 * int'(mbank) + t) % 64));
    endtask

    always @(negedge clk) begin
        t = cyc - s;
        if (!act || t < 0 || !Resetn) begin
            e_rd = 0; e_go = 0; e_busy = 0; e_cd = 0;
            e_hf = hold_hf; e_to = hold_to; e_d = hold_data; e_op = hold_op;
        end else begin
            e_rd   = (mop != 2'b11) && t <= 15;
            e_go   = !mfail && t == L;
            e_busy = t <= D;
            e_cd   = t == D;
            e_hf   = mfail && t >= D;
            e_to   = dly < 0 && !mfail && t >= D;
            e_op   = mop;
            e_d    = '0;
            if (mop != 2'b11)
                for (int k = 0; k < 16; k++)
                    if (k + 2 <= t) e_d[32*k +: 32] = pat[k];
        end
        cmp("dut0", rd0, go0, busy0, cd0, hf0, to0, a0, op0, d0, 0);
        cmp("dut1", rd1, go1, busy1, cd1, hf1, to1, a1, op1, d1, B1);
        if (rd0) begin
            if (!seen_rd) begin fa0 = a0; fa1 = a1; end
            seen_rd = 1'b1;
            la1 = a1;
            rd_n++;
        end
        if (go0) begin go_n++; go_c = cyc; end
        if (cd0) begin cd_n++; cd_c = cyc; end
    end

    task automatic arm(input logic [1:0] op, bank, input int pid, dly_i);
        for (int k = 0; k < 16; k++) begin
            pat[k] = patv(pid, k);
            mem0[(16 * int'(bank) + k) % 64] = pat[k];
            mem1[(B1 + 16 * int'(bank) + k) % 64] = pat[k];
        end
        mop = op; mbank = bank; dly = dly_i;
        mfail = (op != 2'b11) && model_fail();
        L = (op == 2'b11) ? 0 : 18;
        D = mfail ? 18 : (dly < 0 ? L + 1024 : L + dly + 1);
        go_n = 0; rd_n = 0; cd_n = 0; go_c = -1; cd_c = -1;
        seen_rd = 1'b0; fa0 = '0; fa1 = '0; la1 = '0;
        Collect_Go = 1'b1; Op_Type_In = op; Bank_Sel = bank;
        s = cyc + 1;
        act = 1'b1;
        @(posedge clk); #1;
        Collect_Go = 1'b0; Op_Type_In = ~op; Bank_Sel = ~bank;
    endtask

    task automatic run_op(input logic [1:0] op, bank, input int pid, dly_i,
                          sp, gp);
        arm(op, bank, pid, dly_i);
        while (cyc - s <= D + 2) begin
            TRNG_Done  = (dly >= 0 && cyc - s == L + dly) || (cyc - s == sp);
            Collect_Go = (cyc - s == gp);
            @(posedge clk); #1;
        end
        TRNG_Done = 1'b0; Collect_Go = 1'b0;
        hold_data = '0;
        if (op != 2'b11)
            for (int k = 0; k < 16; k++) hold_data[32*k +: 32] = pat[k];
        hold_op = op; hold_hf = mfail; hold_to = dly < 0 && !mfail;
        act = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem0[i] = '0; mem1[i] = '0; end
        #1 Resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.Busy", 512'(busy0), 512'(0));
        chk("reset.data_in", d0, '0);
        Resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // bank 1, incrementing words, done after 10 cycles
        run_op(2'b00, 2'd1, 0, 10, -9, -9);
        chk("a.word0", 512'(d0[31:0]), 512'(17));
        chk("a.word15", 512'(d0[511:480]), 512'(32));
        chk("a.first_addr0", 512'(fa0), 512'(16));
        chk("a.first_addr1", 512'(fa1), 512'(12));
        chk("a.go_count", 512'(go_n), 512'(1));
        chk("a.done_count", 512'(cd_n), 512'(1));
        chk("a.done_lag", 512'(cd_c - go_c), 512'(11));
        chk("a.hfail", 512'(hf0), 512'(0));

        // words 4..6 repeated
        run_op(2'b01, 2'd0, 1, 5, -9, -9);
        chk("b.hfail", 512'(hf0), 512'(1));
        chk("b.go_count", 512'(go_n), 512'(0));
        chk("b.done_count", 512'(cd_n), 512'(1));

        // reseed: no collection
        run_op(2'b11, 2'd2, 3, 4, -9, -9);
        chk("c.rd_count", 512'(rd_n), 512'(0));
        chk("c.data_in", d0, '0);
        chk("c.op_type", 512'(op0), 512'(3));
        chk("c.go_cycle", 512'(go_c), 512'(s));
        chk("c.go_count", 512'(go_n), 512'(1));

        // two repeats only, stray TRNG_Done during read
        run_op(2'b10, 2'd1, 4, 3, 8, -9);
        chk("d.hfail", 512'(hf0), 512'(0));
        chk("d.go_count", 512'(go_n), 512'(1));

        // all-zero block
        run_op(2'b00, 2'd0, 2, 5, -9, -9);
        chk("e.hfail", 512'(hf0), 512'(1));

        // TRNG never completes
        run_op(2'b01, 2'd2, 3, -1, -9, -9);
        chk("f.timeout", 512'(to0), 512'(1));
        chk("f.timeout_lag", 512'(cd_c - go_c), 512'(1024));

        // reset while reading word 8
        arm(2'b00, 2'd2, 3, 5);
        while (cyc - s < 8) begin @(posedge clk); #1; end
        Resetn = 1'b0;
        act = 1'b0; hold_data = '0; hold_op = '0; hold_hf = 0; hold_to = 0;
        #1;
        chk("g.rd_en", 512'(rd0), 512'(0));
        chk("g.busy", 512'(busy0), 512'(0));
        chk("g.data_in", d0, '0);
        chk("g.addr", 512'(a0), 512'(0));
        repeat (3) @(posedge clk);
        #1 Resetn = 1'b1;
        rd_n = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("g.rd_after_reset", 512'(rd_n), 512'(0));

        // bank 3, wrap in the BASE_ADDR=60 instance, Collect_Go mid-run
        run_op(2'b00, 2'd3, 0, 6, -9, 5);
        chk("h.first_addr1", 512'(fa1), 512'(44));
        chk("h.last_addr1", 512'(la1), 512'(59));
        chk("h.first_addr0", 512'(fa0), 512'(48));
        chk("h.go_count", 512'(go_n), 512'(1));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/trng_sram_collector.md
TRNG_SRAM_COLLECTOR -- requirements
Module: trng_sram_collector

Interface
REQ-001 Parameter BASE_ADDR, default 0: first SRAM word address of bank 0.
REQ-002 Parameter REP_LIMIT, default 3: consecutive identical words that fail the health test.
REQ-003 Parameter TIMEOUT, default 1024: maximum cycles spent waiting for TRNG_Done.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be rising-edge.
REQ-005 Port Resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port Collect_Go, input, 1: start request, sampled in IDLE only.
REQ-007 Port Op_Type_In, input, 2: operation type, latched at start.
REQ-008 Port Bank_Sel, input, 2: SRAM bank, latched at start; bank base address = BASE_ADDR + 16*Bank_Sel.
REQ-009 Port sram_rd_en, output, 1: SRAM read strobe.
REQ-010 Port sram_addr, output, 6: SRAM word address.
REQ-011 Port sram_rdata, input, 32: SRAM read data, valid exactly 1 cycle after sram_rd_en.
REQ-012 Port TRNG_Go, output, 1: launch pulse to TRNG_Top.
REQ-013 Port Op_Type, output, 2: operation type to TRNG_Top.
REQ-014 Port data_in, output, 512: seed block to TRNG_Top.
REQ-015 Port TRNG_Done, input, 1: completion from TRNG_Top.
REQ-016 Port Busy, output, 1: high in every state except IDLE.
REQ-017 Port Collect_Done, output, 1: one-cycle completion pulse.
REQ-018 Port Health_Fail, output, 1: sticky health-test failure flag.
REQ-019 Port Timeout, output, 1: sticky watchdog flag.

Function
REQ-020 FSM states SHALL be IDLE, READ, CAPTURE_LAST, CHECK, LAUNCH, WAIT_DONE, DONE, FAIL.
REQ-021 IDLE + Collect_Go=1: latch Op_Type_In and Bank_Sel, clear Health_Fail and Timeout, clear data_in to 0. Next state is READ, or LAUNCH if Op_Type_In=2'b11 (reseed; no collection, no health test).
REQ-022 READ: assert sram_rd_en for exactly 16 consecutive cycles, with sram_addr = bank base + k for k = 0..15. Address arithmetic SHALL be 6-bit and wrap modulo 64.
REQ-023 Word k, returned one cycle after its read, SHALL be written to data_in[32k+31:32k].
REQ-024 CAPTURE_LAST: capture word 15 (sram_rd_en low); next state is CHECK. Total READ entry to CHECK entry SHALL be 17 cycles.
REQ-025 CHECK (1 cycle): fail if REP_LIMIT consecutive captured words are identical (run counter updated during capture), or if data_in is all zero. Fail goes to FAIL; otherwise go to LAUNCH.
REQ-026 LAUNCH: TRNG_Go=1 for exactly one cycle, with Op_Type = latched value; next state is WAIT_DONE.
REQ-027 WAIT_DONE: wait for TRNG_Done=1, then go to DONE. If TIMEOUT cycles elapse first, set Timeout and go to DONE.
REQ-028 DONE and FAIL: Collect_Done=1 for one cycle, then return to IDLE. FAIL additionally sets Health_Fail and SHALL NOT assert TRNG_Go.
REQ-029 Collect_Go SHALL be ignored while Busy=1.
REQ-030 data_in and Op_Type SHALL remain stable from LAUNCH until the next accepted Collect_Go.
REQ-031 TRNG_Done arriving outside WAIT_DONE SHALL be ignored.

Reset
REQ-032 While Resetn=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE, including when reset occurs mid-operation. No SRAM read SHALL be issued after reset until a new Collect_Go is accepted.

Structure
REQ-033 FSM state encoding, the word count (16) and the op-code constants (reseed=2'b11) SHALL live in the shared package trng_pkg.
REQ-034 The repetition/all-zero health test SHALL be a sub-module trng_health_test: inputs are word valid and word data; output is the fail flag.

Verification
REQ-035 Bank_Sel=1, SRAM word i = i+1, Op_Type_In=2'b00 -> addresses 16..31, data_in word k = 17+k, exactly one TRNG_Go; TRNG_Done after 10 cycles -> Collect_Done pulse, Health_Fail=0.
REQ-036 Words 4..6 all 32'hA5A5A5A5 -> Health_Fail=1, Collect_Done pulse, no TRNG_Go.
REQ-037 Op_Type_In=2'b11 -> no sram_rd_en, data_in=0, TRNG_Go one cycle after start, Op_Type=2'b11.
REQ-038 TRNG_Done never asserted -> Timeout=1 and Collect_Done exactly 1024 cycles after LAUNCH.
REQ-039 Resetn=0 during READ word 8 -> all outputs 0 immediately; after release, no reads occur until Collect_Go.
REQ-040 Bank_Sel=3 with BASE_ADDR=60 -> addresses wrap 44..59 as computed modulo 64 (60+48=108 mod 64 = 44); Collect_Go pulsed mid-run is ignored.
